// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list and moves
// one register per memory beat, with optional base writeback.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre_index,
  input  logic              up,
  input  logic              writeback,
  input  logic [15:0]       reg_list,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [3:0]        rf_read_num,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [3:0]        rf_write_num,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_XFER, S_WB, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              ld_q, ld_d;
  logic              p_q, p_d;
  logic              u_q, u_d;
  logic              w_q, w_d;
  logic [15:0]       list_q, list_d;
  logic [15:0]       rem_q, rem_d;
  logic [3:0]        breg_q, breg_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fin_q, fin_d;
  logic [3:0]        cur_q, cur_d;

  logic [4:0]        cnt;
  logic [ADDR_W-1:0] n4;
  logic [15:0]       rem_nx;
  logic              wb_ok;

  function automatic logic [3:0] lsb(input logic [15:0] v);
    lsb = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lsb = 4'(i);
  endfunction

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++)
      cnt = cnt + 5'(list_q[i]);
    n4 = ADDR_W'(cnt) << 2;
    rem_nx = rem_q & ~(16'(1) << cur_q);
    // a loaded base register keeps its loaded value
    wb_ok = w_q & ~(ld_q & list_q[breg_q]);
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    p_d     = p_q;
    u_d     = u_q;
    w_d     = w_q;
    list_d  = list_q;
    rem_d   = rem_q;
    breg_d  = breg_q;
    base_d  = base_q;
    addr_d  = addr_q;
    fin_d   = fin_q;
    cur_d   = cur_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ld_d    = is_load;
          p_d     = pre_index;
          u_d     = up;
          w_d     = writeback;
          list_d  = reg_list;
          rem_d   = reg_list;
          breg_d  = base_reg;
          base_d  = base_addr;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        fin_d = u_q ? base_q + n4 : base_q - n4;
        unique case ({p_q, u_q})
          2'b01: addr_d = base_q;
          2'b11: addr_d = base_q + ADDR_W'(4);
          2'b00: addr_d = base_q - n4 + ADDR_W'(4);
          2'b10: addr_d = base_q - n4;
        endcase
        cur_d   = lsb(list_q);
        state_d = (list_q == '0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        if (mem_ready) begin
          rem_d  = rem_nx;
          cur_d  = lsb(rem_nx);
          addr_d = addr_q + ADDR_W'(4);
          if (rem_nx == '0) state_d = S_WB;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    rf_read_num   = '0;
    rf_write_en   = 1'b0;
    rf_write_num  = '0;
    rf_write_data = '0;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    mem_wdata     = rf_read_data;
    if (state_q == S_XFER) begin
      mem_req  = 1'b1;
      mem_we   = ~ld_q;
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (!ld_q) rf_read_num = cur_q;
      if (ld_q && mem_ready) begin
        rf_write_en   = 1'b1;
        rf_write_num  = cur_q;
        rf_write_data = mem_rdata;
      end
    end
    if (state_q == S_WB && wb_ok) begin
      rf_write_en   = 1'b1;
      rf_write_num  = breg_q;
      rf_write_data = DATA_W'(fin_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ld_q    <= 1'b0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      w_q     <= 1'b0;
      list_q  <= '0;
      rem_q   <= '0;
      breg_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      fin_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      p_q     <= p_d;
      u_q     <= u_d;
      w_q     <= w_d;
      list_q  <= list_d;
      rem_q   <= rem_d;
      breg_q  <= breg_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      fin_q   <= fin_d;
      cur_q   <= cur_d;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: fixed-latency scenarios with
// hand-computed addresses, register numbers and data.
module tb_ldm_stm_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        pre_index = 1'b0;
  logic        up = 1'b0;
  logic        writeback = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  rf_read_num;
  logic [31:0] rf_read_data;
  logic        rf_write_en;
  logic [3:0]  rf_write_num;
  logic [31:0] rf_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign rf_read_data = 32'hA000_0000 | 32'(rf_read_num);
  assign mem_rdata    = 32'hD000_0000 | mem_addr;

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .is_load(is_load),
    .pre_index(pre_index), .up(up), .writeback(writeback),
    .reg_list(reg_list), .base_reg(base_reg), .base_addr(base_addr),
    .rf_read_num(rf_read_num), .rf_read_data(rf_read_data),
    .rf_write_en(rf_write_en), .rf_write_num(rf_write_num),
    .rf_write_data(rf_write_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // checks {busy,done,req,we}, addr, read num and write port together
  task automatic cyc(input string tag, input logic [3:0] ctl,
                     input logic [31:0] addr, input logic [3:0] rnum,
                     input logic wen, input logic [3:0] wnum,
                     input logic [31:0] wdata);
    check({tag, ".ctl"}, 64'({busy, done, mem_req, mem_we}), 64'(ctl));
    check({tag, ".addr"}, 64'(mem_addr), 64'(addr));
    check({tag, ".rnum"}, 64'(rf_read_num), 64'(rnum));
    check({tag, ".wr"}, {27'd0, wen, wnum, wdata},
          {27'd0, rf_write_en, rf_write_num, rf_write_data});
  endtask

  // strobes start through edge 0; returns at cycle 1 + 1ns
  task automatic issue(input logic ld, input logic p, input logic u,
                       input logic w, input logic [15:0] lst,
                       input logic [3:0] rn, input logic [31:0] base);
    is_load = ld; pre_index = p; up = u; writeback = w;
    reg_list = lst; base_reg = rn; base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #3;
    cyc("rst", 4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    reset = 1'b1;
    tick();

    // STMIA r4!, {r0,r1,r3}
    issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h000B, 4'd4, 32'h1000);
    cyc("stmia.c1", 4'b1000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("stmia.c2", 4'b1011, 32'h1000, 4'h0, 1'b0, 4'h0, 32'h0);
    check("stmia.wdata", 64'(mem_wdata), 64'h A000_0000);
    tick();
    cyc("stmia.c3", 4'b1011, 32'h1004, 4'h1, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("stmia.c4", 4'b1011, 32'h1008, 4'h3, 1'b0, 4'h0, 32'h0);
    check("stmia.wdata3", 64'(mem_wdata), 64'h A000_0003);
    tick();
    cyc("stmia.wb", 4'b1000, 32'h0, 4'h0, 1'b1, 4'h4, 32'h100C);
    tick();
    cyc("stmia.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("stmia.idle", 4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);

    // LDMDB r13!, {r0,r15}
    issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h8001, 4'd13, 32'h2000);
    tick();
    cyc("ldmdb.c2", 4'b1010, 32'h1FF8, 4'h0, 1'b1, 4'h0, 32'hD000_1FF8);
    tick();
    cyc("ldmdb.c3", 4'b1010, 32'h1FFC, 4'h0, 1'b1, 4'hF, 32'hD000_1FFC);
    tick();
    cyc("ldmdb.wb", 4'b1000, 32'h0, 4'h0, 1'b1, 4'hD, 32'h1FF8);
    tick();
    cyc("ldmdb.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();

    // LDMIB {r1,r2} with two wait states on the first beat
    mem_ready = 1'b0;
    issue(1'b1, 1'b1, 1'b1, 1'b0, 16'h0006, 4'd5, 32'h0100);
    tick();
    cyc("ldmib.w1", 4'b1010, 32'h0104, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("ldmib.w2", 4'b1010, 32'h0104, 4'h0, 1'b0, 4'h0, 32'h0);
    mem_ready = 1'b1;
    #1;
    cyc("ldmib.r1", 4'b1010, 32'h0104, 4'h0, 1'b1, 4'h1, 32'hD000_0104);
    tick();
    cyc("ldmib.r2", 4'b1010, 32'h0108, 4'h0, 1'b1, 4'h2, 32'hD000_0108);
    tick();
    cyc("ldmib.wb", 4'b1000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("ldmib.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();

    // LDMIA r1!, {r0,r1}: loaded base suppresses writeback
    issue(1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 4'd1, 32'h0300);
    tick();
    cyc("ldmia.c2", 4'b1010, 32'h0300, 4'h0, 1'b1, 4'h0, 32'hD000_0300);
    tick();
    cyc("ldmia.c3", 4'b1010, 32'h0304, 4'h0, 1'b1, 4'h1, 32'hD000_0304);
    tick();
    cyc("ldmia.wb", 4'b1000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("ldmia.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();

    // STMDA r2!, {r0,r1}
    issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 4'd2, 32'h0040);
    tick();
    cyc("stmda.c2", 4'b1011, 32'h003C, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("stmda.c3", 4'b1011, 32'h0040, 4'h1, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("stmda.wb", 4'b1000, 32'h0, 4'h0, 1'b1, 4'h2, 32'h0038);
    tick();
    cyc("stmda.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();

    // empty list
    issue(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'd3, 32'h0800);
    cyc("empty.c1", 4'b1000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("empty.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("empty.idle", 4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);

    // reset in the middle of a stalled transfer
    mem_ready = 1'b0;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h000F, 4'd0, 32'h0500);
    tick();
    tick();
    cyc("rstx.pre", 4'b1011, 32'h0500, 4'h0, 1'b0, 4'h0, 32'h0);
    reset = 1'b0;
    #1;
    cyc("rstx.mid", 4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    cyc("rstx.idle", 4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);

    // start while busy is ignored
    issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 4'd7, 32'h0600);
    tick();
    cyc("ign.c2", 4'b1011, 32'h0600, 4'h0, 1'b0, 4'h0, 32'h0);
    start = 1'b1; reg_list = 16'h00FF; base_addr = 32'h0900;
    tick();
    start = 1'b0;
    cyc("ign.c3", 4'b1011, 32'h0604, 4'h1, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("ign.wb", 4'b1000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("ign.done", 4'b1100, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    tick();
    cyc("ign.idle", 4'b0000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
